// File: rtl/cyclic_lamp_array.sv
// Cyclic lamp array: rotate up/down, bounce and blink lamp patterns.
// Blink on mode 11 is only built with CYCLIC_LAMP_BLINK_EN; otherwise 11 rotates up.
module cyclic_lamp_array #(
    parameter int N_LAMPS = 3,
    parameter int DWELL   = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               enable,
    input  logic [1:0]         mode,
    output logic [N_LAMPS-1:0] light,
    output logic               step,
    output logic               wrap
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);
    localparam logic [N_LAMPS-1:0] ONE = N_LAMPS'(1);
    localparam logic [N_LAMPS-1:0] ALL = '1;

    typedef enum logic {
        UP = 1'b0,
        DN = 1'b1
    } dir_t;

    dir_t dir;
    dir_t dir_nx;
    dir_t bnc_dir;

    logic [CW-1:0]      cnt;
    logic               adv;
    logic               onehot;
    logic               is_blink;
    logic               wrap_nx;
    logic [N_LAMPS-1:0] rot_up;
    logic [N_LAMPS-1:0] rot_dn;
    logic [N_LAMPS-1:0] bnc;
    logic [N_LAMPS-1:0] light_nx;

    assign adv    = enable && (cnt == LAST);
    assign onehot = (light != '0) && ((light & (light - ONE)) == '0);

`ifdef CYCLIC_LAMP_BLINK_EN
    assign is_blink = (mode == 2'b11);
`else
    assign is_blink = 1'b0;
`endif

    if (N_LAMPS > 1) begin : g_rot
        assign rot_up = {light[N_LAMPS-2:0], light[N_LAMPS-1]};
        assign rot_dn = {light[0], light[N_LAMPS-1:1]};
    end else begin : g_rot1
        assign rot_up = light;
        assign rot_dn = light;
    end

    // Flip at the ends first, then move, so an end lamp bounces straight back.
    always_comb begin
        bnc     = light;
        bnc_dir = dir;
        if (N_LAMPS > 1) begin
            if (dir == UP && light[N_LAMPS-1]) begin
                bnc_dir = DN;
            end else if (dir == DN && light[0]) begin
                bnc_dir = UP;
            end
            bnc = (bnc_dir == UP) ? (light << 1) : (light >> 1);
        end
    end

    always_comb begin
        light_nx = light;
        dir_nx   = dir;
        wrap_nx  = 1'b0;
        if (is_blink) begin
            light_nx = (light == ALL) ? '0 : ALL;
            wrap_nx  = (light == ALL);
        end else if (!onehot) begin
            light_nx = ONE;
            dir_nx   = UP;
        end else begin
            unique case (mode)
                2'b01: begin
                    light_nx = rot_dn;
                    dir_nx   = UP;
                    wrap_nx  = light[0];
                end
                2'b10: begin
                    light_nx = bnc;
                    dir_nx   = bnc_dir;
                    wrap_nx  = bnc[0];
                end
                default: begin
                    light_nx = rot_up;
                    dir_nx   = UP;
                    wrap_nx  = light[N_LAMPS-1];
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            light <= ONE;
            dir   <= UP;
            step  <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            step <= adv;
            wrap <= adv & wrap_nx;
            if (enable) begin
                cnt <= adv ? '0 : cnt + 1'b1;
            end
            if (adv) begin
                light <= light_nx;
                dir   <= dir_nx;
            end
        end
    end

endmodule

// File: tb/tb_cyclic_lamp_array.sv
// Scoreboard bench for cyclic_lamp_array (N_LAMPS=3/DWELL=2 and N_LAMPS=1/DWELL=1).
// Expected {light,step,wrap} is queued when inputs are driven, checked after the edge.
module tb_cyclic_lamp_array;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       enable;
    logic [1:0] mode;
    logic [2:0] light;
    logic       step;
    logic       wrap;
    logic       en1;
    logic [1:0] mode1;
    logic [0:0] light1;
    logic       step1;
    logic       wrap1;

    cyclic_lamp_array #(.N_LAMPS(3), .DWELL(2)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (enable),
        .mode    (mode),
        .light   (light),
        .step    (step),
        .wrap    (wrap)
    );

    cyclic_lamp_array #(.N_LAMPS(1), .DWELL(1)) dut1 (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (en1),
        .mode    (mode1),
        .light   (light1),
        .step    (step1),
        .wrap    (wrap1)
    );

    always #5 clock = ~clock;

`ifdef CYCLIC_LAMP_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [4:0] sbq[$];
    logic [2:0] sbq1[$];
    logic [4:0] exp5;
    logic [2:0] exp3;
    logic [2:0] m_light;
    int         m_cnt;
    bit         m_up;

    task automatic model_reset();
        m_light = 3'b001;
        m_cnt   = 0;
        m_up    = 1'b1;
        sbq.delete();
    endtask

    // Reference: lamp position as an index, wrap judged on the landing position.
    task automatic predict(input logic en, input logic [1:0] md);
        logic       adv;
        logic       w;
        logic [1:0] eff;
        int         p;
        adv = en && (m_cnt == 1);
        w   = 1'b0;
        if (en) m_cnt = adv ? 0 : m_cnt + 1;
        if (adv) begin
            eff = (md == 2'b11 && !BLINK) ? 2'b00 : md;
            p = -1;
            for (int i = 0; i < 3; i++)
                if (m_light == 3'(1 << i)) p = i;
            if (eff == 2'b11) begin
                w = (m_light == 3'b111);
                m_light = w ? 3'b000 : 3'b111;
            end else if (p < 0) begin
                m_light = 3'b001;
                m_up = 1'b1;
            end else begin
                if (eff == 2'b00) begin
                    p = (p + 1) % 3;
                    w = (p == 0);
                    m_up = 1'b1;
                end else if (eff == 2'b01) begin
                    p = (p + 2) % 3;
                    w = (p == 2);
                    m_up = 1'b1;
                end else begin
                    if (m_up && p == 2) m_up = 1'b0;
                    else if (!m_up && p == 0) m_up = 1'b1;
                    p = m_up ? p + 1 : p - 1;
                    w = (p == 0);
                end
                m_light = 3'(1 << p);
            end
        end
        sbq.push_back({m_light, adv, w});
    endtask

    task automatic drive(input logic en, input logic [1:0] md);
        enable = en;
        mode   = md;
        predict(en, md);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        n_tests++;
        if (light !== 3'b001) begin
            n_fail++;
            $display("FAIL reset_light: got %b want 001", light);
        end
        n_tests++;
        if ({step, wrap} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_pulses: got %b want 00", {step, wrap});
        end
        n_tests++;
        if ({light1, step1, wrap1} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_n1: got %b want 100", {light1, step1, wrap1});
        end
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic run_mode(input string name, input logic en,
                            input logic [1:0] md, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            drive(en, md);
            tick();
            exp5 = sbq.pop_front();
            n_tests++;
            if ({light, step, wrap} !== exp5) begin
                n_fail++;
                $display("FAIL %s[%0d]: got %b want %b",
                         name, i, {light, step, wrap}, exp5);
            end
        end
    endtask

    task automatic test_rotate_up();
        run_mode("rot_up", 1'b1, 2'b00, 8);
    endtask

    task automatic test_rotate_down();
        run_mode("rot_dn", 1'b1, 2'b01, 6);
    endtask

    task automatic test_bounce();
        run_mode("bounce", 1'b1, 2'b10, 16);
    endtask

    task automatic test_enable_hold();
        run_mode("hold_pre", 1'b1, 2'b10, 1);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 2'(i));
            tick();
            exp5 = sbq.pop_front();
            n_tests++;
            if ({light, step, wrap} !== exp5) begin
                n_fail++;
                $display("FAIL hold[%0d]: got %b want %b",
                         i, {light, step, wrap}, exp5);
            end
        end
        run_mode("hold_post", 1'b1, 2'b10, 3);
    endtask

    task automatic test_mode_midwell();
        run_mode("mid_a", 1'b1, 2'b00, 1);
        run_mode("mid_b", 1'b1, 2'b01, 3);
        run_mode("mid_c", 1'b1, 2'b10, 1);
        run_mode("mid_d", 1'b1, 2'b00, 3);
    endtask

    task automatic test_blink();
        run_mode("blink", 1'b1, 2'b11, 6);
        run_mode("blink_exit", 1'b1, 2'b00, 4);
    endtask

    task automatic test_reset_mid_bounce();
        int guard;
        guard = 0;
        do begin
            drive(1'b1, 2'b10);
            tick();
            exp5 = sbq.pop_front();
            n_tests++;
            if ({light, step, wrap} !== exp5) begin
                n_fail++;
                $display("FAIL rst_pre[%0d]: got %b want %b",
                         guard, {light, step, wrap}, exp5);
            end
            guard++;
        end while (!(m_light == 3'b100 && m_cnt == 1) && guard < 20);
        #2 reset_n = 1'b0;
        #1;
        n_tests++;
        if ({light, step, wrap} !== 5'b00100) begin
            n_fail++;
            $display("FAIL rst_async: got %b want 00100", {light, step, wrap});
        end
        #2 reset_n = 1'b1;
        model_reset();
        run_mode("rst_post", 1'b1, 2'b10, 4);
    endtask

    task automatic test_n1();
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            en1   = (i != 9);
            mode1 = 2'(i / 3);
            sbq1.push_back(en1 ? 3'b111 : 3'b100);
            tick();
            exp3 = sbq1.pop_front();
            n_tests++;
            if ({light1, step1, wrap1} !== exp3) begin
                n_fail++;
                $display("FAIL n1[%0d]: got %b want %b",
                         i, {light1, step1, wrap1}, exp3);
            end
        end
    endtask

    initial begin
        enable = 1'b0;
        mode   = 2'b00;
        en1    = 1'b0;
        mode1  = 2'b00;
        model_reset();
        test_reset();
        test_rotate_up();
        test_rotate_down();
        test_bounce();
        test_enable_hold();
        test_mode_midwell();
        test_blink();
        test_reset_mid_bounce();
        test_n1();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
